seg7_capture_decode: RTL and testbench



---
 rtl/seg7_capture_decode.sv | 205 ++++++++++++++++++++
 tb/tb_seg7_capture_decode.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture_decode.sv
// Seven-segment capture/decode: samples a segment bus, waits for a pattern to
// hold steady for STABLE_CYCLES samples, then decodes it back to a hex value.
// Optional build macro SEG7_DP_EN adds a decimal-point input/output that takes
// part in the stability compare and is reported alongside data_out.
module seg7_capture_decode #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [6:0] seg_in,
`ifdef SEG7_DP_EN
    input  logic       dp_in,
    output logic       dp_out,
`endif
    output logic [3:0] data_out,
    output logic       valid,
    output logic       error,
    output logic       blank,
    output logic       update
);

`ifdef SEG7_DP_EN
    localparam int unsigned PW = 8;
`else
    localparam int unsigned PW = 7;
`endif

    localparam logic [7:0] CntLast = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StLock, StBad} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   seg_q, seg_d;
    logic [PW-1:0]   cand_q, cand_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            error_q, error_d;
    logic            blank_q, blank_d;
    logic            update_q, update_d;
    // A value has been reported since reset / disable / error; gates update.
    logic            have_q, have_d;
    logic            dp_q, dp_d;

    logic            glyph_ok;
    logic [3:0]      glyph_val;

    // Invert at the input so everything downstream is active-high; the decimal
    // point shares the segment polarity.
    always_comb begin
`ifdef SEG7_DP_EN
        seg_d = SEG_ACTIVE_LOW ? ~{dp_in, seg_in} : {dp_in, seg_in};
`else
        seg_d = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
`endif
    end

    // Reverse glyph lookup on the candidate's segment bits.
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_val = 4'h0;
        case (cand_q[6:0])
            7'h3F: glyph_val = 4'h0;
            7'h06: glyph_val = 4'h1;
            7'h5B: glyph_val = 4'h2;
            7'h4F: glyph_val = 4'h3;
            7'h66: glyph_val = 4'h4;
            7'h6D: glyph_val = 4'h5;
            7'h7D: glyph_val = 4'h6;
            7'h07: glyph_val = 4'h7;
            7'h7F: glyph_val = 4'h8;
            7'h6F: glyph_val = 4'h9;
            7'h77: glyph_val = 4'hA;
            7'h7C: glyph_val = 4'hB;
            7'h39: glyph_val = 4'hC;
            7'h5E: glyph_val = 4'hD;
            7'h79: glyph_val = 4'hE;
            7'h71: glyph_val = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    // Next-state and registered-output logic for the settle/lock FSM.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = valid_q;
        error_d  = error_q;
        blank_d  = blank_q;
        update_d = 1'b0;
        have_d   = have_q;
        dp_d     = dp_q;

        if (!en) begin
            state_d = StIdle;
            valid_d = 1'b0;
            error_d = 1'b0;
            blank_d = 1'b1;
            have_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (seg_q != '0) begin
                        cand_d  = seg_q;
                        cnt_d   = 8'd1;
                        blank_d = 1'b0;
                        state_d = StSettle;
                    end else begin
                        blank_d = 1'b1;
                    end
                end
                StSettle: begin
                    if (seg_q != cand_q) begin
                        cand_d = seg_q;
                        cnt_d  = 8'd1;
                    end else if (cnt_q == CntLast) begin
                        if (cand_q == '0) begin
                            blank_d = 1'b1;
                            state_d = StIdle;
                        end else if (glyph_ok) begin
                            data_d  = glyph_val;
                            valid_d = 1'b1;
                            error_d = 1'b0;
                            have_d  = 1'b1;
                            state_d = StLock;
`ifdef SEG7_DP_EN
                            dp_d = cand_q[7];
                            if (glyph_val != data_q || cand_q[7] != dp_q || !have_q) begin
                                update_d = 1'b1;
                            end
`else
                            if (glyph_val != data_q || !have_q) begin
                                update_d = 1'b1;
                            end
`endif
                        end else begin
                            valid_d = 1'b0;
                            error_d = 1'b1;
                            have_d  = 1'b0;
                            state_d = StBad;
                        end
                    end else if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StLock, StBad: begin
                    if (seg_q != cand_q) begin
                        valid_d = 1'b0;
                        error_d = 1'b0;
                        cand_d  = seg_q;
                        cnt_d   = 8'd1;
                        state_d = StSettle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            seg_q    <= '0;
            cand_q   <= '0;
            cnt_q    <= 8'd0;
            data_q   <= 4'h0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            blank_q  <= 1'b1;
            update_q <= 1'b0;
            have_q   <= 1'b0;
            dp_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            blank_q  <= blank_d;
            update_q <= update_d;
            have_q   <= have_d;
            dp_q     <= dp_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign error    = error_q;
    assign blank    = blank_q;
    assign update   = update_q;
`ifdef SEG7_DP_EN
    assign dp_out   = dp_q;
`else
    logic unused_dp;
    assign unused_dp = dp_q ^ dp_d;
`endif

endmodule

// File: tb/tb_seg7_capture_decode.sv
// Directed bench for seg7_capture_decode (default parameters).
module tb_seg7_capture_decode;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [6:0] seg_in;
    logic [3:0] data_out;
    logic       valid;
    logic       error;
    logic       blank;
    logic       update;
`ifdef SEG7_DP_EN
    logic       dp_in = 1'b0;
    logic       dp_out;
`endif

    seg7_capture_decode #(
        .STABLE_CYCLES  (4),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .seg_in   (seg_in),
`ifdef SEG7_DP_EN
        .dp_in    (dp_in),
        .dp_out   (dp_out),
`endif
        .data_out (data_out),
        .valid    (valid),
        .error    (error),
        .blank    (blank),
        .update   (update)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt = 0;
    int val_cnt = 0;
    int err_cnt = 0;
    int excl_viol = 0;
    int upd0, val0, err0;
    logic [6:0] glyph [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Mid-cycle monitor: pulse/level counters and the one-hot status rule.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (update === 1'b1) upd_cnt++;
            if (valid === 1'b1) val_cnt++;
            if (error === 1'b1) err_cnt++;
            if ($countones({valid, error, blank}) > 1) excl_viol++;
        end
    end

    initial begin
        glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
        glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
        glyph[8]  = 7'h7F; glyph[9]  = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
        glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;

        rst_n  = 1'b0;
        en     = 1'b0;
        seg_in = 7'h00;
        #12;
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_blank", 32'(blank), 32'h1);
        check("rst_update", 32'(update), 32'h0);

        // Single glyph '2' from reset: accepted on edge 5.
        @(negedge clk);
        rst_n  = 1'b1;
        en     = 1'b1;
        seg_in = 7'h5B;
        tick(1);
        check("t1_e1_blank", 32'(blank), 32'h1);
        tick(1);
        check("t1_e2_blank", 32'(blank), 32'h0);
        tick(2);
        check("t1_e4_valid", 32'(valid), 32'h0);
        check("t1_e4_update", 32'(update), 32'h0);
        tick(1);
        check("t1_e5_valid", 32'(valid), 32'h1);
        check("t1_e5_data", 32'(data_out), 32'h2);
        check("t1_e5_update", 32'(update), 32'h1);
        tick(1);
        check("t1_e6_update", 32'(update), 32'h0);
        check("t1_e6_valid", 32'(valid), 32'h1);

        // Sweep all sixteen glyphs.
        upd0 = upd_cnt;
        err0 = err_cnt;
        for (int i = 0; i < 16; i++) begin
            seg_in = glyph[i];
            tick(10);
            check($sformatf("sweep_%0d", i), 32'(data_out), 32'(i));
        end
        check("sweep_updates", 32'(upd_cnt - upd0), 32'd16);
        check("sweep_errors", 32'(err_cnt - err0), 32'd0);

        // Single-cycle glitch while locked on '3'.
        seg_in = 7'h4F;
        tick(10);
        check("gl_pre_data", 32'(data_out), 32'h3);
        check("gl_pre_valid", 32'(valid), 32'h1);
        upd0   = upd_cnt;
        seg_in = 7'h4E;
        tick(1);
        seg_in = 7'h4F;
        tick(1);
        check("gl_drop_valid", 32'(valid), 32'h0);
        check("gl_drop_data", 32'(data_out), 32'h3);
        tick(3);
        check("gl_still_low", 32'(valid), 32'h0);
        tick(1);
        check("gl_relock_valid", 32'(valid), 32'h1);
        check("gl_relock_data", 32'(data_out), 32'h3);
        tick(2);
        check("gl_no_update", 32'(upd_cnt - upd0), 32'd0);

        // Illegal pattern, then recovery to '1'.
        seg_in = 7'h01;
        tick(4);
        check("bad_e4_error", 32'(error), 32'h0);
        tick(1);
        check("bad_e5_error", 32'(error), 32'h1);
        check("bad_e5_valid", 32'(valid), 32'h0);
        upd0   = upd_cnt;
        seg_in = 7'h06;
        tick(10);
        check("rec_error", 32'(error), 32'h0);
        check("rec_valid", 32'(valid), 32'h1);
        check("rec_data", 32'(data_out), 32'h1);
        check("rec_update", 32'(upd_cnt - upd0), 32'd1);

        // Toggling faster than the stability window never locks.
        en = 1'b0;
        tick(1);
        check("tog_off_valid", 32'(valid), 32'h0);
        upd0 = upd_cnt;
        val0 = val_cnt;
        en   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            seg_in = (i % 2 == 0) ? 7'h3F : 7'h06;
            tick(3);
        end
        check("tog_valid", 32'(val_cnt - val0), 32'd0);
        check("tog_update", 32'(upd_cnt - upd0), 32'd0);

        // Lock on 'F', disable, then asynchronous reset mid-settle.
        seg_in = 7'h71;
        tick(10);
        check("off_pre_data", 32'(data_out), 32'hF);
        en = 1'b0;
        tick(1);
        check("off_blank", 32'(blank), 32'h1);
        check("off_valid", 32'(valid), 32'h0);
        check("off_data", 32'(data_out), 32'hF);
        check("off_update", 32'(update), 32'h0);
        en     = 1'b1;
        seg_in = 7'h3F;
        tick(2);
        check("mid_blank", 32'(blank), 32'h0);
        check("mid_valid", 32'(valid), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data", 32'(data_out), 32'h0);
        check("arst_valid", 32'(valid), 32'h0);
        check("arst_error", 32'(error), 32'h0);
        check("arst_blank", 32'(blank), 32'h1);
        check("arst_update", 32'(update), 32'h0);

        check("exclusive_status", 32'(excl_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
